// File: rtl/load_align_unit.sv
// load_align_unit: load completion block. Takes address-generated loads,
// issues word-aligned D-cache requests, matches in-order responses back to
// their load-queue entries, aligns and extends the addressed data and writes
// results back in program order.
// Optional feature macro: LOAD_ALIGN_MISALIGN_TRAP_EN (misaligned loads are
// not sent to the D-cache and write back with wb_exc_o set).
module load_align_unit #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_sign_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             dc_req_valid_o,
    input  logic             dc_req_ready_i,
    output logic [31:0]      dc_req_addr_o,
    input  logic             dc_rsp_valid_i,
    input  logic [31:0]      dc_rsp_data_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [31:0]      wb_data_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic             wb_exc_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Repeated flushes can stack stale responses beyond one queue's worth.
    localparam int DROP_W = PTR_W + 3;

    // Load queue payload
    logic [1:0]       off_q  [DEPTH];
    logic [1:0]       size_q [DEPTH];
    logic             sign_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] done_q;

    // Load queue / issue queue control
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  iq_mem [DEPTH];
    logic [PTR_W-1:0]  iq_rd_q, iq_rd_d, iq_wr_q, iq_wr_d;
    logic [CNT_W-1:0]  iq_cnt_q, iq_cnt_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // One-entry D-cache request register
    logic              rq_vld_q;
    logic [31:0]       rq_addr_q;
    logic [PTR_W-1:0]  rq_idx_q;

    logic full, dc_hs, accept, retire, rsp_take, rsp_drop, misal;

    // Select the addressed byte/halfword/word and extend it to 32 bits.
    function automatic logic [31:0] align_ext(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = sgn ? 32'(b) : {24'h0, b};
            2'b01:   r = sgn ? 32'(h) : {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
    logic exc_q [DEPTH];
    assign misal = (req_size_i == 2'b01 && req_addr_i[0]) ||
                   (req_size_i[1] && req_addr_i[1:0] != 2'b00);
    assign wb_exc_o = wb_valid_o & exc_q[head_q];
`else
    assign misal    = 1'b0;
    assign wb_exc_o = 1'b0;
`endif

    assign full        = (count_q == CNT_W'(DEPTH));
    assign dc_hs       = rq_vld_q && dc_req_ready_i;
    assign req_ready_o = !full && (!rq_vld_q || dc_hs);
    assign accept      = req_valid_i && req_ready_o && !flush_i;
    assign retire      = done_q[head_q] && wb_ready_i && !flush_i;
    assign rsp_drop    = dc_rsp_valid_i && (drop_cnt_q != '0);
    assign rsp_take    = dc_rsp_valid_i && (drop_cnt_q == '0) &&
                         (iq_cnt_q != '0) && !flush_i;

    assign dc_req_valid_o = rq_vld_q;
    assign dc_req_addr_o  = rq_addr_q;
    assign wb_valid_o     = done_q[head_q];
    assign wb_data_o      = wb_valid_o ? data_q[head_q] : 32'h0;
    assign wb_tag_o       = wb_valid_o ? tag_q[head_q] : '0;

    // Next-state for pointers, occupancy counts and the stale-response counter.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        iq_rd_d    = iq_rd_q;
        iq_wr_d    = iq_wr_q;
        iq_cnt_d   = iq_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            iq_rd_d  = '0;
            iq_wr_d  = '0;
            iq_cnt_d = '0;
            // Everything still owed by the D-cache becomes stale; a response
            // arriving at this edge pays off one of them.
            drop_cnt_d = drop_cnt_q + DROP_W'(iq_cnt_q) + DROP_W'(dc_hs)
                       - DROP_W'(dc_rsp_valid_i && (drop_cnt_q != '0 || iq_cnt_q != '0));
        end else begin
            if (accept)   tail_d  = tail_q + PTR_W'(1);
            if (retire)   head_d  = head_q + PTR_W'(1);
            if (dc_hs)    iq_wr_d = iq_wr_q + PTR_W'(1);
            if (rsp_take) iq_rd_d = iq_rd_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(accept) - CNT_W'(retire);
            iq_cnt_d = iq_cnt_q + CNT_W'(dc_hs) - CNT_W'(rsp_take);
            if (rsp_drop) drop_cnt_d = drop_cnt_q - DROP_W'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            iq_rd_q    <= '0;
            iq_wr_q    <= '0;
            iq_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            iq_rd_q    <= iq_rd_d;
            iq_wr_q    <= iq_wr_d;
            iq_cnt_q   <= iq_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // D-cache request register: loaded on accept, freed on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rq_vld_q  <= 1'b0;
            rq_addr_q <= 32'h0;
            rq_idx_q  <= '0;
        end else if (flush_i) begin
            rq_vld_q <= 1'b0;
        end else if (accept && !misal) begin
            rq_vld_q  <= 1'b1;
            rq_addr_q <= {req_addr_i[31:2], 2'b00};
            rq_idx_q  <= tail_q;
        end else if (dc_hs) begin
            rq_vld_q <= 1'b0;
        end
    end

    // Per-entry done flags: set by response (or trapped allocate), cleared on retire.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            done_q <= '0;
        end else begin
            if (retire)   done_q[head_q] <= 1'b0;
            if (rsp_take) done_q[iq_mem[iq_rd_q]] <= 1'b1;
            if (accept)   done_q[tail_q] <= misal;
        end
    end

    // Entry payload and issue-queue storage.
    always_ff @(posedge clk) begin
        if (accept) begin
            off_q[tail_q]  <= req_addr_i[1:0];
            size_q[tail_q] <= req_size_i;
            sign_q[tail_q] <= req_sign_i;
            tag_q[tail_q]  <= req_tag_i;
            data_q[tail_q] <= 32'h0;
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
            exc_q[tail_q]  <= misal;
`endif
        end
        if (rsp_take) begin
            data_q[iq_mem[iq_rd_q]] <= align_ext(dc_rsp_data_i, off_q[iq_mem[iq_rd_q]],
                                                 size_q[iq_mem[iq_rd_q]],
                                                 sign_q[iq_mem[iq_rd_q]]);
        end
        if (dc_hs && !flush_i) begin
            iq_mem[iq_wr_q] <= rq_idx_q;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit with a behavioural D-cache and an
// in-order writeback scoreboard.
module tb_load_align_unit;

    localparam int TAG_W = 7;

    logic             clk;
    logic             reset;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [31:0]      req_addr_i;
    logic [1:0]       req_size_i;
    logic             req_sign_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             dc_req_valid_o;
    logic             dc_req_ready_i;
    logic [31:0]      dc_req_addr_o;
    logic             dc_rsp_valid_i;
    logic [31:0]      dc_rsp_data_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [31:0]      wb_data_o;
    logic [TAG_W-1:0] wb_tag_o;
    logic             wb_exc_o;

    load_align_unit #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i),
        .req_sign_i(req_sign_i), .req_tag_i(req_tag_i),
        .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
        .dc_req_addr_o(dc_req_addr_o), .dc_rsp_valid_i(dc_rsp_valid_i),
        .dc_rsp_data_i(dc_rsp_data_i), .wb_valid_o(wb_valid_o),
        .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .wb_tag_o(wb_tag_o), .wb_exc_o(wb_exc_o)
    );

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             exc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pend[$];
    logic [31:0] dmem [logic [31:0]];
    int          pcnt = 0;
    int          tcnt = 0;
    int          dc_issues = 0;
    bit          rsp_en = 1;
    bit          acc_seen = 0;
    logic [31:0] exp_data_nx;
    logic        exp_exc_nx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tcnt++;
        assert (obs === exp) pcnt++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 32'h0;
    endfunction

    // Reference alignment: shift the lane down, mask to width, fill upward.
    function automatic logic [31:0] mdl(input logic [31:0] w, input logic [1:0] off,
                                        input logic [1:0] sz, input logic sg);
        int          nb;
        logic [31:0] v, m;
        nb = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        if (nb == 32) return w;
        v = (nb == 8) ? (w >> (8 * off)) : (w >> (16 * off[1]));
        m = (32'h1 << nb) - 32'h1;
        v = v & m;
        if (sg && v[nb-1]) v = v | ~m;
        return v;
    endfunction

    // One clock: sample handshakes before the edge, update the D-cache model after.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        exp_t        e;
        #1;
        hs = dc_req_valid_o && dc_req_ready_i;
        a  = dc_req_addr_o;
        if (flush_i) begin
            sb.delete();
        end else begin
            if (req_valid_i && req_ready_o) begin
                sb.push_back('{tag: req_tag_i, data: exp_data_nx, exc: exp_exc_nx});
                acc_seen = 1;
            end
            if (wb_valid_o === 1'b1 && wb_ready_i) begin
                chk("wb_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wb_tag", 32'(wb_tag_o), 32'(e.tag));
                    chk("wb_data", wb_data_o, e.data);
                    chk("wb_exc", 32'(wb_exc_o), 32'(e.exc));
                end
            end
        end
        @(posedge clk);
        #1;
        if (hs === 1'b1) begin
            pend.push_back(a);
            dc_issues++;
        end
        dc_rsp_valid_i = 1'b0;
        dc_rsp_data_i  = 32'h0;
        if (rsp_en && pend.size() != 0) begin
            dc_rsp_valid_i = 1'b1;
            dc_rsp_data_i  = rd(pend.pop_front());
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                        input logic [TAG_W-1:0] tg, input logic [31:0] ex);
        req_addr_i  = a;
        req_size_i  = sz;
        req_sign_i  = sg;
        req_tag_i   = tg;
        req_valid_i = 1'b1;
        exp_data_nx = ex;
        exp_exc_nx  = 1'b0;
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
        if ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00)) begin
            exp_data_nx = 32'h0;
            exp_exc_nx  = 1'b1;
        end
`endif
        acc_seen = 0;
        for (int i = 0; i < 50 && !acc_seen; i++) tick();
        req_valid_i = 1'b0;
        chk("accept", 32'(acc_seen), 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        int iss0;
        logic [31:0] a, w;
        logic [1:0]  sz;
        logic        sg;

        reset = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0;
        req_addr_i = 32'h0; req_size_i = 2'b00; req_sign_i = 1'b0; req_tag_i = '0;
        dc_req_ready_i = 1'b1; dc_rsp_valid_i = 1'b0; dc_rsp_data_i = 32'h0;
        wb_ready_i = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_dc_valid", 32'(dc_req_valid_o), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_wb_exc", 32'(wb_exc_o), 32'd0);
        chk("rst_dc_addr", dc_req_addr_o, 32'h0);
        chk("rst_wb_data", wb_data_o, 32'h0);
        chk("rst_wb_tag", 32'(wb_tag_o), 32'h0);

        // Signed byte from the top lane; minimum latency.
        dmem[32'h1000] = 32'h80AABBCC;
        load(32'h1003, 2'b00, 1'b1, 7'd5, 32'hFFFFFF80);
        chk("t1_dc_valid", 32'(dc_req_valid_o), 32'd1);
        chk("t1_dc_addr", dc_req_addr_o, 32'h1000);
        tick();
        chk("t1_wb_not_yet", 32'(wb_valid_o), 32'd0);
        tick();
        chk("t1_wb_valid_T3", 32'(wb_valid_o), 32'd1);
        chk("t1_wb_data", wb_data_o, 32'hFFFFFF80);
        drain(20);

        // Upper halfword, zero- then sign-extended.
        dmem[32'h2000] = 32'hBEEF1234;
        load(32'h2002, 2'b01, 1'b0, 7'd6, 32'h0000BEEF);
        load(32'h2002, 2'b01, 1'b1, 7'd7, 32'hFFFFBEEF);
        drain(20);

        // Fill the queue with writeback stalled, then retire in order.
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h8000 + 32'(4 * i);
            dmem[a] = 32'hA000_0000 + 32'(i);
            load(a, 2'b10, 1'b0, 7'(10 + i), 32'hA000_0000 + 32'(i));
        end
        req_addr_i = 32'h8010; req_tag_i = 7'd14; req_valid_i = 1'b1;
        #1;
        chk("full_ready_low", 32'(req_ready_o), 32'd0);
        req_valid_i = 1'b0;
        repeat (4) tick();
        chk("full_ready_still_low", 32'(req_ready_o), 32'd0);
        wb_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("retire_valid", 32'(wb_valid_o), 32'd1);
            chk("retire_tag", 32'(wb_tag_o), 32'(10 + i));
            tick();
        end
        chk("retire_empty", 32'(wb_valid_o), 32'd0);
        drain(5);

        // Flush with two requests outstanding; stale responses must be dropped.
        rsp_en = 0;
        dmem[32'h4000] = 32'hDEAD0001;
        dmem[32'h4004] = 32'hDEAD0002;
        load(32'h4000, 2'b10, 1'b0, 7'd20, 32'hDEAD0001);
        load(32'h4004, 2'b10, 1'b0, 7'd21, 32'hDEAD0002);
        tick();
        chk("flush_two_issued", pend.size(), 2);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        chk("flush_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("flush_dc_valid", 32'(dc_req_valid_o), 32'd0);
        chk("flush_ready", 32'(req_ready_o), 32'd1);
        rsp_en = 1;
        dmem[32'h5000] = 32'h11223344;
        load(32'h5000, 2'b10, 1'b0, 7'd22, 32'h11223344);
        drain(20);
        chk("flush_drop_done", 32'(dut.drop_cnt_q), 32'd0);

        // D-cache back-pressure: request held, no duplicate issue.
        dc_req_ready_i = 1'b0;
        dmem[32'h6008] = 32'h0BADF00D;
        dmem[32'h600C] = 32'h000000F1;
        load(32'h6008, 2'b10, 1'b0, 7'd30, 32'h0BADF00D);
        iss0 = dc_issues;
        req_addr_i = 32'h600C; req_size_i = 2'b00; req_sign_i = 1'b1;
        req_tag_i = 7'd31; req_valid_i = 1'b1;
        exp_data_nx = 32'hFFFFFFF1; exp_exc_nx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(dc_req_valid_o), 32'd1);
            chk("stall_addr", dc_req_addr_o, 32'h6008);
            chk("stall_ready", 32'(req_ready_o), 32'd0);
            tick();
        end
        chk("stall_no_issue", dc_issues, iss0);
        dc_req_ready_i = 1'b1;
        load(32'h600C, 2'b00, 1'b1, 7'd31, 32'hFFFFFFF1);
        drain(20);
        chk("stall_issue_count", dc_issues, iss0 + 2);

        // Low offset bits below the access size; size 2'b11 behaves as word.
        dmem[32'h9000] = 32'h89ABCDEF;
        load(32'h9003, 2'b10, 1'b1, 7'd35, 32'h89ABCDEF);
        load(32'h9001, 2'b01, 1'b1, 7'd36, 32'hFFFFCDEF);
        load(32'h9000, 2'b11, 1'b0, 7'd37, 32'h89ABCDEF);
        drain(20);

`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
        dmem[32'h3004] = 32'h00001111;
        dmem[32'h3008] = 32'h00002222;
        iss0 = dc_issues;
        load(32'h3004, 2'b10, 1'b0, 7'd40, 32'h00001111);
        load(32'h3001, 2'b10, 1'b0, 7'd41, 32'h0);
        load(32'h3008, 2'b10, 1'b0, 7'd42, 32'h00002222);
        drain(20);
        chk("trap_issue_count", dc_issues, iss0 + 2);
`endif

        // Mixed sizes, offsets and signs against the reference model.
        for (int i = 0; i < 12; i++) begin
            a  = 32'h7000 + 32'(4 * i) + 32'($urandom_range(0, 3));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            w  = $urandom;
            dmem[{a[31:2], 2'b00}] = w;
            load(a, sz, sg, 7'(50 + i), mdl(w, a[1:0], sz, sg));
        end
        drain(40);

        $display("%0d/%0d checks passed", pcnt, tcnt);
        $finish;
    end

endmodule
